seq_divider: RTL and testbench

- Sequential unsigned restoring divider; it is the inverse companion of the team's n-bit Booth multiplier.
- It divides a 2n-bit dividend, such as a multiplier product, by an n-bit divisor.
- Result is an n-bit quotient and an n-bit remainder, one quotient bit per clock.
- It uses the same Start/Finish handshake as the multiplier, so the same bench style and test-vector flow drive both blocks.

---
 rtl/seq_divider.sv | 156 +++++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Sequential unsigned restoring divider: a 2n-bit dividend divided by an n-bit
// divisor gives an n-bit quotient and an n-bit remainder, one quotient bit per
// clock. It uses the Start/Finish handshake of the Booth multiplier.
//
// Ports
//   clk        in   1     system clock, rising edge
//   Reset      in   1     asynchronous, active-high reset
//   Start      in   1     level input; an operation launches on its rising edge
//   Dividend   in   2n    unsigned dividend, captured at launch
//   Divisor    in   n     unsigned divisor, captured at launch
//   Finish     out  1     result valid, held until the next launch
//   Quotient   out  n     registered quotient
//   Remainder  out  n     registered remainder
//   Overflow   out  1     quotient does not fit in n bits, or divide by zero
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned n = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2*n-1:0]   Dividend,
    input  logic [n-1:0]     Divisor,
    output logic             Finish,
    output logic [n-1:0]     Quotient,
    output logic [n-1:0]     Remainder,
    output logic             Overflow
);

    localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            start_q;
    // Operands were captured on the previous edge; dispatch happens this cycle.
    logic            load_q, load_d;
    logic [n-1:0]    r_q, r_d;
    logic [n-1:0]    q_q, q_d;
    logic [n-1:0]    d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fin_q, fin_d;
    logic [n-1:0]    quot_q, quot_d;
    logic [n-1:0]    rem_q, rem_d;
    logic            ovf_q, ovf_d;

    logic            launch_c;
    logic [n:0]      r_sh_c;
    logic            ge_c;
    logic [n-1:0]    r_nx_c;
    logic [n-1:0]    q_nx_c;

    assign Finish    = fin_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign Overflow  = ovf_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            load_q  <= 1'b0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= Start;
            load_q  <= load_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, datapath step and output logic
    always_comb begin
        state_d  = state_q;
        load_d   = 1'b0;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;

        launch_c = Start & ~start_q;

        // One restoring step: shift {R,Q} left, trial-subtract D. R < D holds
        // before the shift, so the shifted R needs only one extra bit and the
        // difference always fits back into n bits.
        r_sh_c   = {r_q, q_q[n-1]};
        ge_c     = (r_sh_c >= {1'b0, d_q});
        r_nx_c   = ge_c ? (r_sh_c[n-1:0] - d_q) : r_sh_c[n-1:0];
        q_nx_c   = {q_q[n-2:0], ge_c};

        case (state_q)
            IDLE, DONE: begin
                if (launch_c) begin
                    r_d    = Dividend[2*n-1:n];
                    q_d    = Dividend[n-1:0];
                    d_d    = Divisor;
                    load_d = 1'b1;
                    fin_d  = 1'b0;
                    ovf_d  = 1'b0;
                end else if (load_q) begin
                    // High half >= divisor means the quotient needs > n bits.
                    if ((d_q == '0) || (r_q >= d_q)) begin
                        state_d = DONE;
                        fin_d   = 1'b1;
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                r_d   = r_nx_c;
                q_d   = q_nx_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(n - 1)) begin
                    state_d = DONE;
                    fin_d   = 1'b1;
                    quot_d  = q_nx_c;
                    rem_d   = r_nx_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] Dividend;
    logic [7:0]  Divisor;
    logic        Finish;
    logic [7:0]  Quotient;
    logic [7:0]  Remainder;
    logic        Overflow;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       o;
        int         fin;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic prev_fin = 1'b0;

    logic [7:0]  rt_mp [8];
    logic [7:0]  rt_mc [8];

    seq_divider #(.n(8)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Finish    (Finish),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Drive a launch at the current negedge and queue its expected result.
    task automatic issue(input logic [15:0] dv, input logic [7:0] ds,
                         input logic [7:0] eq, input logic [7:0] er, input logic eo);
        exp_t e;
        Dividend = dv;
        Divisor  = ds;
        Start    = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.o   = eo;
        e.fin = cyc + 1 + (eo ? 1 : 9);
        sb.push_back(e);
    endtask

    task automatic op(input logic [15:0] dv, input logic [7:0] ds,
                      input logic [7:0] eq, input logic [7:0] er, input logic eo);
        @(negedge clk);
        issue(dv, ds, eq, er, eo);
        tick(2);
        Start = 1'b0;
        tick(10);
    endtask

    // Monitor: each rising Finish pops one expected result.
    always @(negedge clk) begin
        if (!Reset) begin
            if (Finish && !prev_fin) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("quotient",  32'(Quotient),  32'(mon_e.q));
                    chk("remainder", 32'(Remainder), 32'(mon_e.r));
                    chk("overflow",  32'(Overflow),  32'(mon_e.o));
                    chk("latency",   32'(cyc),       32'(mon_e.fin));
                end
            end
        end
        prev_fin = Finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [15:0] prod;
        rt_mp = '{8'd0, 8'd1, 8'd255, 8'd200, 8'd17,  8'd128, 8'd99,  8'd255};
        rt_mc = '{8'd1, 8'd1, 8'd255, 8'd13,  8'd250, 8'd2,   8'd101, 8'd1};

        Reset    = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        @(negedge clk);
        chk("rst_finish",    32'(Finish),    32'd0);
        chk("rst_quotient",  32'(Quotient),  32'd0);
        chk("rst_remainder", 32'(Remainder), 32'd0);
        chk("rst_overflow",  32'(Overflow),  32'd0);
        Reset = 1'b0;
        tick(2);

        // Basic, near-limit, overflow and divide-by-zero
        op(16'd100,  8'd7,   8'd14,  8'd2,  1'b0);
        op(16'hFE00, 8'hFF,  8'hFE,  8'hFE, 1'b0);
        op(16'hFF00, 8'hFF,  8'hFF,  8'h00, 1'b1);
        op(16'h1234, 8'h00,  8'hFF,  8'h00, 1'b1);

        // Start held high: exactly one operation
        @(negedge clk);
        issue(16'd1000, 8'd10, 8'd100, 8'd0, 1'b0);
        tick(20);
        chk("hold_finish", 32'(Finish), 32'd1);
        Start    = 1'b0;
        Dividend = 16'hABCD;
        Divisor  = 8'h03;
        tick(3);
        chk("done_hold_q",   32'(Quotient),  32'd100);
        chk("done_hold_r",   32'(Remainder), 32'd0);
        chk("done_hold_fin", 32'(Finish),    32'd1);
        issue(16'd500, 8'd9, 8'd55, 8'd5, 1'b0);
        tick(1);
        chk("launch_drop_fin", 32'(Finish),   32'd0);
        chk("busy_hold_q",     32'(Quotient), 32'd100);
        tick(1);
        Start = 1'b0;
        tick(10);

        // Reset in the middle of an operation
        @(negedge clk);
        Dividend = 16'h0F0F;
        Divisor  = 8'h21;
        Start    = 1'b1;
        tick(1);
        Start = 1'b0;
        tick(4);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_finish",    32'(Finish),    32'd0);
        chk("midrst_quotient",  32'(Quotient),  32'd0);
        chk("midrst_remainder", 32'(Remainder), 32'd0);
        chk("midrst_overflow",  32'(Overflow),  32'd0);
        @(negedge clk);
        #2 Reset = 1'b0;
        tick(12);
        chk("idle_after_rst_fin", 32'(Finish),   32'd0);
        chk("idle_after_rst_q",   32'(Quotient), 32'd0);

        // Round trip against multiplier products
        for (int i = 0; i < 8; i++) begin
            prod = {8'd0, rt_mp[i]} * {8'd0, rt_mc[i]};
            op(prod, rt_mc[i], rt_mp[i], 8'd0, 1'b0);
        end

        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
